bcd_down_counter: RTL and testbench

//  Multi-digit BCD countdown timer; the complement of the up-counting BCD digit chain.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_down_digit.sv | 51 +++++
 rtl/bcd_down_counter.sv | 172 +++++++++++++++++
 tb/tb_bcd_down_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer slice.
// Contents:
//   BCD_W      - bits per BCD digit
//   BCD_MAX    - largest legal BCD digit value (9)
//   state_e    - timer FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   clamp_bcd  - forces a nibble into the legal BCD range 0..9
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Nibbles A..F cannot be shown on a BCD display; saturate them to 9.
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain.
// Ports:
//   clk        in   system clock (posedge)
//   rst_n      in   asynchronous active-low reset, clears the digit to 0
//   dec_en     in   chain-wide decrement request for this cycle
//   borrow_in  in   borrow from the next less significant digit (1 for digit 0)
//   load       in   load load_val (overrides any decrement)
//   load_val   in   value to load, already in BCD range
//   digit      out  registered digit value
//   borrow_out out  this digit wraps 0->9 this cycle, so the next digit must decrement
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_en,
  input  logic             borrow_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;
  logic             step;

  // The digit only moves when the whole chain decrements and every lower digit borrowed.
  assign step       = dec_en & borrow_in;
  assign borrow_out = step & (digit_q == '0);

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (step) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer. Loaded with a preset, it counts down one
// unit per prescaled tick and stops at zero with a one-cycle done pulse.
// Optional feature macro: BCD_DOWN_AUTORELOAD_EN - when defined, reaching zero
// pulses oDone but keeps running, and the following tick reloads the preset
// (periodic timer with period preset+1 ticks).
// Parameters:
//   DIGITS    number of BCD digits, digit 0 least significant
//   PRESCALE  iClk cycles per count tick (>= 1)
// Ports:
//   iClk      in   system clock (posedge)
//   iRst_n    in   asynchronous active-low reset
//   iLoad     in   load preset, highest priority, returns to IDLE
//   iLoadVal  in   preset, nibble k = digit k, nibbles above 9 clamp to 9
//   iStart    in   start / resume counting
//   iStop     in   pause counting, value held
//   oDigits   out  registered BCD value
//   oBusy     out  1 while running
//   oZero     out  1 when all digits are 0
//   oDone     out  one-cycle pulse on the tick that reaches 0
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iLoadVal,
  input  logic                  iStart,
  input  logic                  iStop,
  output logic [4*DIGITS-1:0]   oDigits,
  output logic                  oBusy,
  output logic                  oZero,
  output logic                  oDone
);

  localparam int VW = BCD_W * DIGITS;
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [VW-1:0]   reload_q, reload_d;
  logic            done_q, done_d;

  logic [VW-1:0]   load_clamped;
  logic [VW-1:0]   load_val;
  logic            load_en;
  logic            dec_en;
  logic            value_one;
  logic [DIGITS:0] borrow;

  always_comb begin
    load_clamped = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_clamped[k*BCD_W +: BCD_W] = clamp_bcd(iLoadVal[k*BCD_W +: BCD_W]);
    end
  end

  // Digit 0 always takes part in a decrement; higher digits ripple the borrow
  // within the same cycle.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (iClk),
      .rst_n      (iRst_n),
      .dec_en     (dec_en),
      .borrow_in  (borrow[g]),
      .load       (load_en),
      .load_val   (load_val[g*BCD_W +: BCD_W]),
      .digit      (oDigits[g*BCD_W +: BCD_W]),
      .borrow_out (borrow[g+1])
    );
  end

  // A borrow out of the top digit would mean decrementing 000, which the FSM never requests.
  always_comb begin
    assert (!borrow[DIGITS]);
  end

  assign oZero     = (oDigits == '0);
  // The decrement that lands on zero is the one applied while the value is exactly 1.
  assign value_one = (oDigits == VW'(1));

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    dec_en   = 1'b0;
    load_en  = 1'b0;
    load_val = load_clamped;

    if (iLoad) begin
      load_en  = 1'b1;
      reload_d = load_clamped;
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart && !iStop) begin
            presc_d = '0;
            if (oZero) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (iStop) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (oZero) begin
`ifdef BCD_DOWN_AUTORELOAD_EN
              // Tick after the zero pulse restarts the period from the preset.
              if (reload_q != '0) begin
                load_en  = 1'b1;
                load_val = reload_q;
              end else begin
                state_d = ST_DONE;
              end
`else
              state_d = ST_DONE;
`endif
            end else begin
              dec_en = 1'b1;
              if (value_one) begin
                done_d = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
                state_d = ST_RUN;
`else
                state_d = ST_DONE;
`endif
              end
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign oBusy = (state_q == ST_RUN);
  assign oDone = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed testbench for bcd_down_counter with DIGITS=3.
// Two instances share the command inputs: dut1 uses PRESCALE=1 and dut4 uses
// PRESCALE=4. Build with BCD_DOWN_AUTORELOAD_EN defined to exercise the
// periodic reload behaviour as well.
module tb_bcd_down_counter;

`ifdef BCD_DOWN_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        iClk;
   logic        iRst_n;
   logic        iLoad;
   logic [11:0] iLoadVal;
   logic        iStart;
   logic        iStop;

   logic [11:0] digits1, digits4;
   logic        busy1, busy4;
   logic        zero1, zero4;
   logic        done1, done4;

   int assertCount;
   int failCount;

   bcd_down_counter #(.DIGITS(3), .PRESCALE(1)) dut1 (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iLoad    (iLoad),
      .iLoadVal (iLoadVal),
      .iStart   (iStart),
      .iStop    (iStop),
      .oDigits  (digits1),
      .oBusy    (busy1),
      .oZero    (zero1),
      .oDone    (done1)
   );

   bcd_down_counter #(.DIGITS(3), .PRESCALE(4)) dut4 (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iLoad    (iLoad),
      .iLoadVal (iLoadVal),
      .iStart   (iStart),
      .iStop    (iStop),
      .oDigits  (digits4),
      .oBusy    (busy4),
      .oZero    (zero4),
      .oDone    (done4)
   );

   // Free-running 10 ns clock.
   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advances n clock edges, leaving time 1 ns after the last edge.
   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   // Holds a command for exactly one clock edge, then clears all commands.
   task automatic applyStimulus(input logic load, input logic [11:0] val, input logic start, input logic stop);
      iLoad    = load;
      iLoadVal = val;
      iStart   = start;
      iStop    = stop;
      waitCycles(1);
      iLoad    = 1'b0;
      iStart   = 1'b0;
      iStop    = 1'b0;
   endtask

   logic [11:0] seq1 [6];

   initial begin
      assertCount = 0;
      failCount   = 0;
      iRst_n   = 1'b0;
      iLoad    = 1'b0;
      iLoadVal = 12'h000;
      iStart   = 1'b0;
      iStop    = 1'b0;

      // Reset state
      #3;
      checkOutput("rst_digits", 32'(digits1), 32'h000);
      checkOutput("rst_busy",   32'(busy1),   32'd0);
      checkOutput("rst_done",   32'(done1),   32'd0);
      checkOutput("rst_zero",   32'(zero1),   32'd1);
      #8 iRst_n = 1'b1;
      waitCycles(1);

      // Test 1: PRESCALE=1 countdown with double borrow 100 -> 099
      $display("[TB] test 1: prescale 1 countdown from 105");
      applyStimulus(1'b1, 12'h105, 1'b0, 1'b0);
      checkOutput("t1_load", 32'(digits1), 32'h105);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      checkOutput("t1_busy", 32'(busy1), 32'd1);
      seq1 = '{12'h104, 12'h103, 12'h102, 12'h101, 12'h100, 12'h099};
      for (int i = 0; i < 6; i++) begin
         waitCycles(1);
         checkOutput($sformatf("t1_seq%0d", i), 32'(digits1), 32'(seq1[i]));
      end
      waitCycles(98);
      checkOutput("t1_at001",   32'(digits1), 32'h001);
      checkOutput("t1_nodone",  32'(done1),   32'd0);
      waitCycles(1);
      checkOutput("t1_at000",   32'(digits1), 32'h000);
      checkOutput("t1_done",    32'(done1),   32'd1);
      checkOutput("t1_zero",    32'(zero1),   32'd1);
      checkOutput("t1_busyend", 32'(busy1),   32'(AUTO));
      waitCycles(1);
      checkOutput("t1_donepulse", 32'(done1),   32'd0);
      checkOutput("t1_after",     32'(digits1), AUTO ? 32'h105 : 32'h000);

      // Test 2: PRESCALE=4, one decrement per four cycles
      $display("[TB] test 2: prescale 4 countdown from 002");
      applyStimulus(1'b1, 12'h002, 1'b0, 1'b0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("t2_hold3",  32'(digits4), 32'h002);
      waitCycles(1);
      checkOutput("t2_at4",    32'(digits4), 32'h001);
      checkOutput("t2_nodone", 32'(done4),   32'd0);
      waitCycles(3);
      checkOutput("t2_hold7",  32'(digits4), 32'h001);
      waitCycles(1);
      checkOutput("t2_at8",    32'(digits4), 32'h000);
      checkOutput("t2_done",   32'(done4),   32'd1);
      waitCycles(1);
      checkOutput("t2_donepulse", 32'(done4), 32'd0);

      // Test 3: clamp on load, start from zero goes straight to DONE
      $display("[TB] test 3: clamp and start from zero");
      applyStimulus(1'b1, 12'hAF3, 1'b0, 1'b0);
      checkOutput("t3_clamp", 32'(digits1), 32'h993);
      applyStimulus(1'b1, 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      checkOutput("t3_done",   32'(done1),   32'd1);
      checkOutput("t3_norun",  32'(busy1),   32'd0);
      checkOutput("t3_digits", 32'(digits1), 32'h000);
      waitCycles(1);
      checkOutput("t3_donepulse", 32'(done1), 32'd0);

      // Test 4: stop holds value, start resumes
      $display("[TB] test 4: pause and resume");
      applyStimulus(1'b1, 12'h050, 1'b0, 1'b0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("t4_at047", 32'(digits1), 32'h047);
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
      waitCycles(10);
      checkOutput("t4_held", 32'(digits1), 32'h047);
      checkOutput("t4_idle", 32'(busy1),   32'd0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitCycles(1);
      checkOutput("t4_resume", 32'(digits1), 32'h046);

      // Test 5: load with stop and start overrides a run; reset mid-run
      $display("[TB] test 5: load abort and async reset");
      applyStimulus(1'b1, 12'h050, 1'b0, 1'b0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitCycles(2);
      checkOutput("t5_at048", 32'(digits1), 32'h048);
      applyStimulus(1'b1, 12'h300, 1'b1, 1'b1);
      checkOutput("t5_load",   32'(digits1), 32'h300);
      checkOutput("t5_idle",   32'(busy1),   32'd0);
      checkOutput("t5_nodone", 32'(done1),   32'd0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitCycles(1);
      checkOutput("t5_at299", 32'(digits1), 32'h299);
      iRst_n = 1'b0;
      #1;
      checkOutput("t5_rst_digits", 32'(digits1), 32'h000);
      checkOutput("t5_rst_busy",   32'(busy1),   32'd0);
      checkOutput("t5_rst_zero",   32'(zero1),   32'd1);
      #2 iRst_n = 1'b1;
      waitCycles(1);
      checkOutput("t5_post_digits", 32'(digits1), 32'h000);
      checkOutput("t5_post_busy",   32'(busy1),   32'd0);

`ifdef BCD_DOWN_AUTORELOAD_EN
      // Test 6: periodic reload
      $display("[TB] test 6: auto-reload");
      applyStimulus(1'b1, 12'h002, 1'b0, 1'b0);
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
      waitCycles(1);
      checkOutput("t6_001a", 32'(digits1), 32'h001);
      waitCycles(1);
      checkOutput("t6_000a", 32'(digits1), 32'h000);
      checkOutput("t6_donea", 32'(done1),  32'd1);
      checkOutput("t6_busya", 32'(busy1),  32'd1);
      waitCycles(1);
      checkOutput("t6_reload", 32'(digits1), 32'h002);
      checkOutput("t6_nodone", 32'(done1),   32'd0);
      waitCycles(1);
      checkOutput("t6_001b", 32'(digits1), 32'h001);
      waitCycles(1);
      checkOutput("t6_000b", 32'(digits1), 32'h000);
      checkOutput("t6_doneb", 32'(done1),  32'd1);
      checkOutput("t6_busyb", 32'(busy1),  32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
